// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader.
// This covers the state encoding and the default geometry of the boot image.
package imem_boot_loader_pkg;

  localparam int unsigned WORD_W_DEF    = 32;
  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DEPTH_DEF     = 64;
  localparam int unsigned BASE_ADDR_DEF = 4;
  localparam int unsigned STEP_DEF      = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot sequencer for the instruction memory: clear all entries, stream a program in,
// then release the core. Owns the memory write port and muxes the read address.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned STEP      = STEP_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ld_start,
  input  logic                     i_ld_valid,
  input  logic [WORD_W-1:0]        i_ld_data,
  input  logic                     i_ld_last,
  output logic                     o_ld_ready,
  input  logic [ADDR_W-1:0]        i_core_pc,
  output logic [ADDR_W-1:0]        o_imem_raddr,
  output logic                     o_imem_we,
  output logic [ADDR_W-1:0]        o_imem_waddr,
  output logic [WORD_W-1:0]        o_imem_wdata,
  output logic                     o_core_stall,
  output logic                     o_core_pc_rst,
  output logic [$clog2(DEPTH):0]   o_word_cnt,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [2:0]        r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_clr_idx, w_clr_idx_nxt;
  logic [ADDR_W-1:0] r_wptr, w_wptr_nxt;
  logic [CNT_W-1:0]  r_word_cnt, w_word_cnt_nxt;
  logic              r_err, w_err_nxt;

  logic w_accept;
  logic w_overflow;
  logic w_load_we;

  // A restart pulse wins over a word offered in the same cycle.
  assign w_accept   = (r_state == S_LOAD) && i_ld_valid && !i_ld_start;
  assign w_overflow = r_wptr >= ADDR_W'(DEPTH);
  assign w_load_we  = w_accept && !w_overflow;

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_idx_nxt  = r_clr_idx;
    w_wptr_nxt     = r_wptr;
    w_word_cnt_nxt = r_word_cnt;
    w_err_nxt      = r_err;
    if (i_ld_start) begin
      w_state_nxt    = S_CLEAR;
      w_clr_idx_nxt  = '0;
      w_word_cnt_nxt = '0;
      w_err_nxt      = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_CLEAR: begin
          w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
          if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
            w_state_nxt    = S_LOAD;
            w_wptr_nxt     = ADDR_W'(BASE_ADDR);
            w_word_cnt_nxt = '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_overflow) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_FAULT;
            end else begin
              w_wptr_nxt     = r_wptr + ADDR_W'(STEP);
              w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
              if (i_ld_last) w_state_nxt = S_RELEASE;
            end
          end
        end
        S_RELEASE: w_state_nxt = S_RUN;
        S_RUN:     ;
        S_FAULT:   ;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_clr_idx  <= '0;
      r_wptr     <= '0;
      r_word_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_idx  <= w_clr_idx_nxt;
      r_wptr     <= w_wptr_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    o_imem_we    = (r_state == S_CLEAR) || w_load_we;
    o_imem_waddr = '0;
    if (r_state == S_CLEAR) o_imem_waddr = ADDR_W'(r_clr_idx);
    else if (r_state == S_LOAD) o_imem_waddr = r_wptr;
    o_imem_wdata = w_load_we ? i_ld_data : '0;
  end

  assign o_ld_ready    = (r_state == S_LOAD);
  assign o_imem_raddr  = (r_state == S_RUN) ? i_core_pc : '0;
  assign o_core_stall  = (r_state != S_RUN);
  assign o_core_pc_rst = (r_state == S_RELEASE);
  assign o_busy        = (r_state == S_CLEAR) || (r_state == S_LOAD);
  assign o_word_cnt    = r_word_cnt;
  assign o_err         = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected memory writes are queued by the stimulus
// and matched by a monitor on every write strobe; status outputs are checked inline.
module tb_imem_boot_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [31:0] core_pc;
  logic [31:0] imem_raddr;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_stall;
  logic        core_pc_rst;
  logic [6:0]  word_cnt;
  logic        busy;
  logic        err;

  int  checks;
  int  errors;
  wr_t exp_q[$];

  imem_boot_loader dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ld_start    (ld_start),
    .i_ld_valid    (ld_valid),
    .i_ld_data     (ld_data),
    .i_ld_last     (ld_last),
    .o_ld_ready    (ld_ready),
    .i_core_pc     (core_pc),
    .o_imem_raddr  (imem_raddr),
    .o_imem_we     (imem_we),
    .o_imem_waddr  (imem_waddr),
    .o_imem_wdata  (imem_wdata),
    .o_core_stall  (core_stall),
    .o_core_pc_rst (core_pc_rst),
    .o_word_cnt    (word_cnt),
    .o_busy        (busy),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] data, input logic last, input bit expect_wr,
                      input logic [31:0] addr);
    wr_t e;
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    if (expect_wr) begin
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
    end
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Start pulse (optionally with a competing word) followed by the full 64-entry clear.
  task automatic do_clear(input bit with_valid);
    wr_t e;
    for (int i = 0; i < 64; i++) begin
      e.addr = 32'(i);
      e.data = 32'h0;
      exp_q.push_back(e);
    end
    ld_start = 1'b1;
    ld_valid = with_valid;
    ld_data  = 32'hDEAD_BEEF;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk("clear_busy", {31'b0, busy}, 32'd1);
    chk("clear_err_cleared", {31'b0, err}, 32'd0);
    chk("clear_word_cnt", {25'b0, word_cnt}, 32'd0);
    chk("clear_ld_ready", {31'b0, ld_ready}, 32'd0);
    for (int i = 0; i < 64; i++) tick();
    chk("load_ready", {31'b0, ld_ready}, 32'd1);
    chk("clear_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    core_pc  = 32'd12;

    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (imem_we) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     imem_waddr, imem_wdata);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", imem_waddr, e.addr);
            chk("write_data", imem_wdata, e.data);
          end
        end
      end
    join_none

    // Reset state and idle with no start.
    repeat (3) tick();
    chk("rst_stall", {31'b0, core_stall}, 32'd1);
    chk("rst_we", {31'b0, imem_we}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_pc_rst", {31'b0, core_pc_rst}, 32'd0);
    chk("rst_word_cnt", {25'b0, word_cnt}, 32'd0);
    chk("rst_waddr", imem_waddr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_stall", {31'b0, core_stall}, 32'd1);
      chk("idle_ready", {31'b0, ld_ready}, 32'd0);
    end

    // Clear, then a 10-word program and release.
    do_clear(1'b0);
    chk("load_raddr_muted", imem_raddr, 32'd0);
    for (int i = 0; i < 10; i++)
      send(32'hA000_0000 + 32'(i), (i == 9), 1'b1, 32'(4 + 4 * i));
    chk("release_pc_rst", {31'b0, core_pc_rst}, 32'd1);
    chk("release_stall", {31'b0, core_stall}, 32'd1);
    chk("release_word_cnt", {25'b0, word_cnt}, 32'd10);
    tick();
    chk("run_pc_rst", {31'b0, core_pc_rst}, 32'd0);
    chk("run_stall", {31'b0, core_stall}, 32'd0);
    chk("run_busy", {31'b0, busy}, 32'd0);
    chk("run_raddr", imem_raddr, 32'd12);
    core_pc = 32'h20;
    #1;
    chk("run_raddr_track", imem_raddr, 32'h20);
    send(32'h1111_1111, 1'b0, 1'b0, 32'd0);
    chk("run_ready", {31'b0, ld_ready}, 32'd0);
    chk("load_drained", 32'(exp_q.size()), 32'd0);

    // Overflow: 15 words fit at 4..60, the 16th faults.
    do_clear(1'b0);
    for (int i = 0; i < 15; i++)
      send(32'hB000_0000 + 32'(i), 1'b0, 1'b1, 32'(4 + 4 * i));
    chk("full_ready", {31'b0, ld_ready}, 32'd1);
    chk("full_word_cnt", {25'b0, word_cnt}, 32'd15);
    send(32'hB000_000F, 1'b0, 1'b0, 32'd0);
    chk("fault_err", {31'b0, err}, 32'd1);
    chk("fault_stall", {31'b0, core_stall}, 32'd1);
    chk("fault_ready", {31'b0, ld_ready}, 32'd0);
    chk("fault_busy", {31'b0, busy}, 32'd0);
    send(32'hB000_0010, 1'b1, 1'b0, 32'd0);
    chk("fault_err_held", {31'b0, err}, 32'd1);
    chk("fault_word_cnt", {25'b0, word_cnt}, 32'd15);

    // Restart from FAULT, then a restart that collides with a word mid-load.
    do_clear(1'b0);
    for (int i = 0; i < 3; i++)
      send(32'hC000_0000 + 32'(i), 1'b0, 1'b1, 32'(4 + 4 * i));
    chk("mid_word_cnt", {25'b0, word_cnt}, 32'd3);
    do_clear(1'b1);

    // Gaps in ld_valid hold the write pointer.
    send(32'hD000_0001, 1'b0, 1'b1, 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gap_word_cnt", {25'b0, word_cnt}, 32'd1);
    end
    send(32'hD000_0002, 1'b1, 1'b1, 32'd8);
    chk("gap_release", {31'b0, core_pc_rst}, 32'd1);
    chk("gap_word_cnt2", {25'b0, word_cnt}, 32'd2);
    tick();
    chk("gap_run_stall", {31'b0, core_stall}, 32'd0);

    // Asynchronous reset part-way through a clear.
    for (int i = 0; i < 10; i++) begin
      wr_t e;
      e.addr = 32'(i);
      e.data = 32'h0;
      exp_q.push_back(e);
    end
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_we", {31'b0, imem_we}, 32'd0);
    chk("abort_stall", {31'b0, core_stall}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_word_cnt", {25'b0, word_cnt}, 32'd0);
    repeat (3) tick();
    chk("abort_drained", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_idle_stall", {31'b0, core_stall}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
